systolic_byte_responder: RTL



---
 rtl/systolic_byte_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/systolic_byte_responder.sv
// Byte-wide host-port slave holding 2x2 A/B operands and C results, with a
// sequential one-MAC-per-cycle matrix-multiply engine (C = A x B).
module systolic_byte_responder #(
    parameter int unsigned A_BASE = 0,
    parameter int unsigned B_BASE = 32,
    parameter int unsigned C_BASE = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [5:0] addr,
    input  logic       write_en,
    input  logic       read_en,
    input  logic       start,
    output logic       ready,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [5:0] ABase = A_BASE[5:0];
    localparam logic [5:0] BBase = B_BASE[5:0];
    localparam logic [5:0] CBase = C_BASE[5:0];

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic        ready_d, done_d;

    // A index = 2i+t, B index = 2t+j, C index = 2i+j
    logic [15:0] a_q [4];
    logic [15:0] b_q [4];
    logic [31:0] c_q [4];

    logic [5:0]  a_off, b_off, c_off;
    logic        a_hit, b_hit, c_hit;
    logic [7:0]  rdata;
    logic [31:0] c_word;
    logic        wr_ok, start_go;
    logic [1:0]  ai, bi, ci;
    logic [31:0] ext_a, ext_b, mult;

    assign a_off = addr - ABase;
    assign b_off = addr - BBase;
    assign c_off = addr - CBase;
    assign a_hit = a_off < 6'd8;
    assign b_hit = b_off < 6'd8;
    assign c_hit = c_off < 6'd16;

    assign wr_ok    = write_en && (state_q != StBusy);
    assign start_go = start && (state_q != StBusy);

    // k = {i, j, t}
    assign ai    = {k_q[2], k_q[0]};
    assign bi    = {k_q[0], k_q[1]};
    assign ci    = {k_q[2], k_q[1]};
    assign ext_a = {{16{a_q[ai][15]}}, a_q[ai]};
    assign ext_b = {{16{b_q[bi][15]}}, b_q[bi]};
    // Low 32 bits of the product are identical for signed and unsigned operands.
    assign mult  = ext_a * ext_b;

    assign c_word = c_q[c_off[3:2]];

    always_comb begin
        rdata = 8'h00;
        if (a_hit) begin
            rdata = a_off[0] ? a_q[a_off[2:1]][15:8] : a_q[a_off[2:1]][7:0];
        end else if (b_hit) begin
            rdata = b_off[0] ? b_q[b_off[2:1]][15:8] : b_q[b_off[2:1]][7:0];
        end else if (c_hit) begin
            unique case (c_off[1:0])
                2'd0:    rdata = c_word[7:0];
                2'd1:    rdata = c_word[15:8];
                2'd2:    rdata = c_word[23:16];
                default: rdata = c_word[31:24];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StBusy;
                    k_d     = 3'd0;
                end
            end
            StBusy: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d != StBusy);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            ready   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ready   <= ready_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                a_q[n] <= 16'h0000;
                b_q[n] <= 16'h0000;
                c_q[n] <= 32'h0000_0000;
            end
            data_out <= 8'h00;
        end else begin
            if (wr_ok && a_hit) begin
                if (a_off[0]) a_q[a_off[2:1]][15:8] <= data_in;
                else          a_q[a_off[2:1]][7:0]  <= data_in;
            end
            if (wr_ok && b_hit) begin
                if (b_off[0]) b_q[b_off[2:1]][15:8] <= data_in;
                else          b_q[b_off[2:1]][7:0]  <= data_in;
            end
            if (start_go) begin
                for (int n = 0; n < 4; n++) begin
                    c_q[n] <= 32'h0000_0000;
                end
            end else if (state_q == StBusy) begin
                c_q[ci] <= c_q[ci] + mult;
            end
            if (read_en && !write_en) begin
                data_out <= rdata;
            end
        end
    end

endmodule
